// File: rtl/asip_crypto_top.sv
// Small multi-cycle ASIP for GF(2^m) code-based crypto kernels: instruction SRAM,
// 18 single-port data banks and an 8-register core driven by a FETCH/EXEC/LOAD FSM.

module asip_sram #(
  parameter int W  = 13,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [0:(1<<AW)-1];

  // Read-before-write single port; read data is registered.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

module asip_dat_banks #(
  parameter int W  = 13,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic [17:0]          we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [W-1:0]         wdata_i,
  output logic [17:0][W-1:0]   rdata_o
);
  // Banks are named individually so they can be preloaded by hierarchical path.
  asip_sram #(.W(W), .AW(AW)) dat_sram0  (.clk(clk), .we_i(we_i[0]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[0]));
  asip_sram #(.W(W), .AW(AW)) dat_sram1  (.clk(clk), .we_i(we_i[1]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[1]));
  asip_sram #(.W(W), .AW(AW)) dat_sram2  (.clk(clk), .we_i(we_i[2]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[2]));
  asip_sram #(.W(W), .AW(AW)) dat_sram3  (.clk(clk), .we_i(we_i[3]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[3]));
  asip_sram #(.W(W), .AW(AW)) dat_sram4  (.clk(clk), .we_i(we_i[4]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[4]));
  asip_sram #(.W(W), .AW(AW)) dat_sram5  (.clk(clk), .we_i(we_i[5]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[5]));
  asip_sram #(.W(W), .AW(AW)) dat_sram6  (.clk(clk), .we_i(we_i[6]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[6]));
  asip_sram #(.W(W), .AW(AW)) dat_sram7  (.clk(clk), .we_i(we_i[7]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[7]));
  asip_sram #(.W(W), .AW(AW)) dat_sram8  (.clk(clk), .we_i(we_i[8]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[8]));
  asip_sram #(.W(W), .AW(AW)) dat_sram9  (.clk(clk), .we_i(we_i[9]),  .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[9]));
  asip_sram #(.W(W), .AW(AW)) dat_sram10 (.clk(clk), .we_i(we_i[10]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[10]));
  asip_sram #(.W(W), .AW(AW)) dat_sram11 (.clk(clk), .we_i(we_i[11]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[11]));
  asip_sram #(.W(W), .AW(AW)) dat_sram12 (.clk(clk), .we_i(we_i[12]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[12]));
  asip_sram #(.W(W), .AW(AW)) dat_sram13 (.clk(clk), .we_i(we_i[13]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[13]));
  asip_sram #(.W(W), .AW(AW)) dat_sram14 (.clk(clk), .we_i(we_i[14]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[14]));
  asip_sram #(.W(W), .AW(AW)) dat_sram15 (.clk(clk), .we_i(we_i[15]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[15]));
  asip_sram #(.W(W), .AW(AW)) dat_sram16 (.clk(clk), .we_i(we_i[16]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[16]));
  asip_sram #(.W(W), .AW(AW)) dat_sram17 (.clk(clk), .we_i(we_i[17]), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o[17]));
endmodule

module asip_crypto_top #(
  parameter int               MEM_W  = 13,
  parameter logic [MEM_W-1:0] POLY   = 13'h001B,
  parameter int               INS_W  = 24,
  parameter int               INS_AW = 8,
  parameter int               DAT_AW = 8,
  parameter int               NBANK  = 18
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             t_cs,
  output logic [MEM_W-1:0] out
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_LOAD, S_HALT} state_e;

  localparam logic [3:0] OP_LD   = 4'h1, OP_ST  = 4'h2, OP_XOR = 4'h3, OP_AND = 4'h4;
  localparam logic [3:0] OP_GFM  = 4'h5, OP_SHL = 4'h6, OP_LDI = 4'h7, OP_JMP = 4'h8;
  localparam logic [3:0] OP_BNZ  = 4'h9, OP_OUT = 4'hA, OP_HLT = 4'hF;

  state_e                       state_q, state_d;
  logic [INS_AW-1:0]            pc_q, pc_d;
  logic [7:0][MEM_W-1:0]        regs_q, regs_d;
  logic [MEM_W-1:0]             out_q, out_d;
  logic [2:0]                   ld_rd_q, ld_rd_d;
  logic [4:0]                   ld_bank_q, ld_bank_d;
  logic                         st_en;
  logic [INS_W-1:0]             ir;
  logic [NBANK-1:0]             dat_we;
  logic [NBANK-1:0][MEM_W-1:0]  bank_rdata;
  logic [MEM_W-1:0]             load_data;

  wire [3:0]        op   = ir[23:20];
  wire [2:0]        rd   = ir[19:17];
  wire [2:0]        rs1  = ir[16:14];
  wire [2:0]        rs2  = ir[13:11];
  wire [4:0]        bank = ir[16:12];
  wire [INS_AW-1:0] addr = ir[INS_AW-1:0];

  // Horner-style shift-and-add: reduce on every shift, add a when the b bit is set.
  function automatic logic [MEM_W-1:0] gf_mul(input logic [MEM_W-1:0] a, input logic [MEM_W-1:0] b);
    logic [MEM_W-1:0] p;
    p = '0;
    for (int i = MEM_W - 1; i >= 0; i--) begin
      p = {p[MEM_W-2:0], 1'b0} ^ (p[MEM_W-1] ? POLY : '0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  asip_sram #(.W(INS_W), .AW(INS_AW)) ins_sram (
    .clk(clk), .we_i(1'b0), .addr_i(pc_q), .wdata_i('0), .rdata_o(ir)
  );

  asip_dat_banks #(.W(MEM_W), .AW(DAT_AW)) dat_sram (
    .clk(clk), .we_i(dat_we), .addr_i(ir[DAT_AW-1:0]), .wdata_i(regs_q[rd]), .rdata_o(bank_rdata)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_we
      assign dat_we[gi] = st_en && (bank == 5'(gi));
    end
  endgenerate

  // Out-of-range banks read back as zero.
  always_comb begin
    load_data = '0;
    for (int b = 0; b < NBANK; b++)
      if (ld_bank_q == 5'(b)) load_data = bank_rdata[b];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (t_cs) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  begin
        if (op == OP_LD)       state_d = S_LOAD;
        else if (op == OP_HLT) state_d = S_HALT;
        else                   state_d = S_FETCH;
      end
      S_LOAD:  state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    st_en = (state_q == S_EXEC) && (op == OP_ST);
  end

  always_comb begin
    pc_d      = pc_q;
    regs_d    = regs_q;
    out_d     = out_q;
    ld_rd_d   = ld_rd_q;
    ld_bank_d = ld_bank_q;
    unique case (state_q)
      S_IDLE: if (t_cs) pc_d = '0;
      S_EXEC: begin
        pc_d = pc_q + 1'b1;
        case (op)
          OP_LD:  begin ld_rd_d = rd; ld_bank_d = bank; end
          OP_XOR: regs_d[rd] = regs_q[rs1] ^ regs_q[rs2];
          OP_AND: regs_d[rd] = regs_q[rs1] & regs_q[rs2];
          OP_GFM: regs_d[rd] = gf_mul(regs_q[rs1], regs_q[rs2]);
          OP_SHL: regs_d[rd] = {regs_q[rs1][MEM_W-2:0], 1'b0};
          OP_LDI: regs_d[rd] = ir[MEM_W-1:0];
          OP_JMP: pc_d = addr;
          OP_BNZ: if (regs_q[rd] != '0) pc_d = addr;
          OP_OUT: out_d = regs_q[rd];
          default: ;
        endcase
      end
      S_LOAD: regs_d[ld_rd_q] = load_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pc_q      <= '0;
      regs_q    <= '0;
      out_q     <= '0;
      ld_rd_q   <= '0;
      ld_bank_q <= '0;
    end else begin
      pc_q      <= pc_d;
      regs_q    <= regs_d;
      out_q     <= out_d;
      ld_rd_q   <= ld_rd_d;
      ld_bank_q <= ld_bank_d;
    end
  end

  assign out = out_q;
endmodule

// File: tb/tb_asip_crypto_top.sv
// Scoreboard bench for asip_crypto_top: each test loads a program by backdoor, queues the
// expected out changes with their cycle offsets, and a negedge monitor pops and compares.

module tb_asip_crypto_top;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        t_cs = 1'b0;
  logic [12:0] out;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LD = 4'h1, OP_ST = 4'h2, OP_XOR = 4'h3, OP_AND = 4'h4;
  localparam logic [3:0] OP_GFM = 4'h5, OP_SHL = 4'h6, OP_JMP = 4'h8, OP_BNZ = 4'h9, OP_OUT = 4'hA;
  localparam logic [23:0] HALT = 24'hF00000;

  always #5 clk = ~clk;

  asip_crypto_top dut (.clk(clk), .reset_b(reset_b), .t_cs(t_cs), .out(out));

  typedef struct { logic [12:0] val; int cyc; string tag; } exp_t;
  exp_t        sb[$];
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          mon_en = 0;
  logic [12:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of out is one transaction, matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && out !== last_out) begin
      last_out = out;
      $display("out=%h cycle=%0d", out, cyc - start_cyc);
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: out=%h at cycle %0d, required no change", out, cyc - start_cyc);
      end else begin
        e = sb.pop_front();
        if (out !== e.val) begin
          errors++;
          $display("FAIL out_value[%s]: got %h required %h", e.tag, out, e.val);
        end
        if (e.cyc >= 0) begin
          vectors++;
          if (cyc - start_cyc != e.cyc) begin
            errors++;
            $display("FAIL out_cycle[%s]: got %0d required %0d", e.tag, cyc - start_cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required program completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] i_r(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction
  function automatic logic [23:0] i_ldi(logic [2:0] rd, logic [12:0] imm);
    return {4'h7, rd, 4'd0, imm};
  endfunction
  function automatic logic [23:0] i_mem(logic [3:0] op, logic [2:0] rd, logic [4:0] bank, logic [7:0] a);
    return {op, rd, bank, 4'd0, a};
  endfunction
  function automatic logic [23:0] i_j(logic [3:0] op, logic [2:0] rd, logic [7:0] a);
    return {op, rd, 9'd0, a};
  endfunction

  // Reference: full carry-less product, then reduce from the top by x^13+x^4+x^3+x+1.
  function automatic logic [12:0] gf_ref(logic [12:0] a, logic [12:0] b);
    logic [24:0] p;
    p = '0;
    for (int i = 0; i < 13; i++) if (b[i]) p = p ^ (25'(a) << i);
    for (int i = 24; i >= 13; i--) if (p[i]) p = p ^ (25'h201B << (i - 13));
    return p[12:0];
  endfunction

  task automatic push(logic [12:0] v, int c, string tag);
    exp_t e;
    e.val = v; e.cyc = c; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) dut.ins_sram.mem[i] = HALT;
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk) reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    sb.delete();
    last_out = out;
  endtask

  task automatic start();
    @(negedge clk) t_cs = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    t_cs = 1'b0;
    last_out = out;
    mon_en = 1;
  endtask

  task automatic wait_empty(int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    clear_prog();
    dut.dat_sram.dat_sram0.mem[0] = 13'h0AAA;
    repeat (10) @(negedge clk);
    vectors++;
    if (out !== 13'h0000) begin errors++; $display("FAIL reset_out: got %h required 0000", out); end
    reset_b = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (out !== 13'h0000) begin errors++; $display("FAIL idle_out: got %h required 0000", out); end
    vectors++;
    if (dut.pc_q !== 8'd0) begin errors++; $display("FAIL idle_pc: got %0d required 0", dut.pc_q); end
    vectors++;
    if (dut.dat_sram.dat_sram0.mem[0] !== 13'h0AAA) begin
      errors++; $display("FAIL idle_no_write: got %h required 0aaa", dut.dat_sram.dat_sram0.mem[0]);
    end
  endtask

  task automatic test_alu_basic();
    do_reset();
    clear_prog();
    dut.ins_sram.mem[0] = i_ldi(3'd1, 13'h0005);
    dut.ins_sram.mem[1] = i_ldi(3'd2, 13'h0003);
    dut.ins_sram.mem[2] = i_r(OP_XOR, 3'd3, 3'd1, 3'd2);
    dut.ins_sram.mem[3] = i_j(OP_OUT, 3'd3, 8'd0);
    start();
    push(13'h0006, 8, "xor");
    wait_empty(40);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL alu_basic_drain: %0d pending, required 0", sb.size()); end
    @(negedge clk) t_cs = 1'b1;
    repeat (3) @(negedge clk);
    t_cs = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (out !== 13'h0006) begin errors++; $display("FAIL halt_hold: got %h required 0006", out); end
  endtask

  task automatic test_alu_ops();
    do_reset();
    clear_prog();
    dut.ins_sram.mem[0]  = i_ldi(3'd1, 13'h1000);
    dut.ins_sram.mem[1]  = i_ldi(3'd2, 13'h0002);
    dut.ins_sram.mem[2]  = i_r(OP_GFM, 3'd3, 3'd1, 3'd2);
    dut.ins_sram.mem[3]  = i_j(OP_OUT, 3'd3, 8'd0);
    dut.ins_sram.mem[4]  = i_ldi(3'd4, 13'h0002);
    dut.ins_sram.mem[5]  = i_ldi(3'd5, 13'h0003);
    dut.ins_sram.mem[6]  = i_r(OP_GFM, 3'd6, 3'd4, 3'd5);
    dut.ins_sram.mem[7]  = i_j(OP_OUT, 3'd6, 8'd0);
    dut.ins_sram.mem[8]  = i_r(OP_AND, 3'd7, 3'd3, 3'd5);
    dut.ins_sram.mem[9]  = 24'hC00000;
    dut.ins_sram.mem[10] = i_j(OP_OUT, 3'd7, 8'd0);
    dut.ins_sram.mem[11] = i_r(OP_SHL, 3'd7, 3'd3, 3'd0);
    dut.ins_sram.mem[12] = i_j(OP_OUT, 3'd7, 8'd0);
    dut.ins_sram.mem[13] = i_r(OP_SHL, 3'd0, 3'd1, 3'd0);
    dut.ins_sram.mem[14] = i_j(OP_OUT, 3'd0, 8'd0);
    start();
    push(13'h001B, 8, "gfmul_x12_x");
    push(13'h0006, 16, "gfmul_2_3");
    push(13'h0003, 22, "and_after_nop");
    push(13'h0036, 26, "shl");
    push(13'h0000, 30, "shl_msb_drop");
    wait_empty(80);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL alu_ops_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_gfmul_random();
    logic [12:0] a, b, r, prev;
    do_reset();
    clear_prog();
    prev = 13'h0000;
    for (int j = 0; j < 8; j++) begin
      a = (j == 0) ? 13'h1FFF : 13'($urandom_range(0, 8191));
      b = (j == 0) ? 13'h1FFF : 13'($urandom_range(0, 8191));
      dut.ins_sram.mem[4*j]   = i_ldi(3'd1, a);
      dut.ins_sram.mem[4*j+1] = i_ldi(3'd2, b);
      dut.ins_sram.mem[4*j+2] = i_r(OP_GFM, 3'd3, 3'd1, 3'd2);
      dut.ins_sram.mem[4*j+3] = i_j(OP_OUT, 3'd3, 8'd0);
      r = gf_ref(a, b);
      if (r != prev) push(r, 8*j + 8, $sformatf("gfmul_%h_%h", a, b));
      prev = r;
    end
    start();
    wait_empty(120);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL gfmul_rand_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_load_store();
    do_reset();
    clear_prog();
    dut.dat_sram.dat_sram7.mem[8'h10]  = 13'h1ABC;
    dut.dat_sram.dat_sram17.mem[8'h20] = 13'h0000;
    dut.dat_sram.dat_sram16.mem[8'h20] = 13'h0555;
    dut.ins_sram.mem[0]  = i_mem(OP_LD, 3'd1, 5'd7, 8'h10);
    dut.ins_sram.mem[1]  = i_j(OP_OUT, 3'd1, 8'd0);
    dut.ins_sram.mem[2]  = i_mem(OP_ST, 3'd1, 5'd17, 8'h20);
    dut.ins_sram.mem[3]  = i_mem(OP_LD, 3'd2, 5'd17, 8'h20);
    dut.ins_sram.mem[4]  = i_ldi(3'd4, 13'h0001);
    dut.ins_sram.mem[5]  = i_r(OP_XOR, 3'd3, 3'd2, 3'd4);
    dut.ins_sram.mem[6]  = i_j(OP_OUT, 3'd3, 8'd0);
    dut.ins_sram.mem[7]  = i_mem(OP_ST, 3'd3, 5'd20, 8'h20);
    dut.ins_sram.mem[8]  = i_mem(OP_LD, 3'd3, 5'd20, 8'h20);
    dut.ins_sram.mem[9]  = i_j(OP_OUT, 3'd3, 8'd0);
    start();
    push(13'h1ABC, 5, "ld_b7");
    push(13'h1ABD, 16, "st_then_ld_b17");
    push(13'h0000, 23, "ld_bank20_zero");
    wait_empty(60);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL ldst_drain: %0d pending, required 0", sb.size()); end
    vectors++;
    if (dut.dat_sram.dat_sram17.mem[8'h20] !== 13'h1ABC) begin
      errors++; $display("FAIL st_b17: got %h required 1abc", dut.dat_sram.dat_sram17.mem[8'h20]);
    end
    vectors++;
    if (dut.dat_sram.dat_sram16.mem[8'h20] !== 13'h0555) begin
      errors++; $display("FAIL st_b16_untouched: got %h required 0555", dut.dat_sram.dat_sram16.mem[8'h20]);
    end
  endtask

  task automatic test_loop();
    do_reset();
    clear_prog();
    dut.ins_sram.mem[0] = i_ldi(3'd1, 13'h0400);
    dut.ins_sram.mem[1] = i_j(OP_OUT, 3'd1, 8'd0);
    dut.ins_sram.mem[2] = i_r(OP_SHL, 3'd1, 3'd1, 3'd0);
    dut.ins_sram.mem[3] = i_j(OP_BNZ, 3'd1, 8'd2);
    dut.ins_sram.mem[4] = i_j(OP_OUT, 3'd1, 8'd0);
    start();
    push(13'h0400, 4, "loop_init");
    push(13'h0000, 18, "loop_exit");
    wait_empty(60);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL loop_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_branch_wrap();
    do_reset();
    clear_prog();
    dut.ins_sram.mem[0]   = i_j(OP_BNZ, 3'd1, 8'd3);
    dut.ins_sram.mem[1]   = i_j(OP_JMP, 3'd0, 8'd254);
    dut.ins_sram.mem[254] = i_ldi(3'd1, 13'h0055);
    dut.ins_sram.mem[255] = i_j(OP_OUT, 3'd1, 8'd0);
    dut.ins_sram.mem[3]   = i_ldi(3'd2, 13'h00AA);
    dut.ins_sram.mem[4]   = i_j(OP_OUT, 3'd2, 8'd0);
    start();
    push(13'h0055, 8, "jmp_254");
    push(13'h00AA, 14, "wrap_bnz_taken");
    wait_empty(60);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL branch_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    clear_prog();
    dut.dat_sram.dat_sram3.mem[8'h05] = 13'h0777;
    dut.dat_sram.dat_sram7.mem[8'h10] = 13'h1ABC;
    dut.ins_sram.mem[0] = i_ldi(3'd1, 13'h0123);
    dut.ins_sram.mem[1] = i_j(OP_OUT, 3'd1, 8'd0);
    dut.ins_sram.mem[2] = i_mem(OP_ST, 3'd1, 5'd3, 8'h05);
    dut.ins_sram.mem[3] = i_mem(OP_LD, 3'd2, 5'd7, 8'h10);
    dut.ins_sram.mem[4] = i_j(OP_OUT, 3'd2, 8'd0);
    for (int run = 0; run < 2; run++) begin
      start();
      push(13'h0123, 4, "pre_reset");
      push(13'h0000, -1, "async_reset");
      // run 0 aborts in the EXEC of ST, run 1 in LOAD
      repeat (run == 0 ? 5 : 8) @(posedge clk);
      #2 reset_b = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (out !== 13'h0000) begin errors++; $display("FAIL midrst_out[%0d]: got %h required 0000", run, out); end
      vectors++;
      if (dut.pc_q !== 8'd0) begin errors++; $display("FAIL midrst_pc[%0d]: got %0d required 0", run, dut.pc_q); end
      vectors++;
      if (dut.dat_sram.dat_sram3.mem[8'h05] !== (run == 0 ? 13'h0777 : 13'h0123)) begin
        errors++; $display("FAIL midrst_store[%0d]: got %h required %h", run,
                           dut.dat_sram.dat_sram3.mem[8'h05], (run == 0 ? 13'h0777 : 13'h0123));
      end
      vectors++;
      if (sb.size() != 0) begin errors++; $display("FAIL midrst_drain[%0d]: %0d pending, required 0", run, sb.size()); end
      reset_b = 1'b1;
      repeat (3) @(negedge clk);
    end
    start();
    push(13'h0123, 4, "rerun_out1");
    push(13'h1ABC, 11, "rerun_ld");
    wait_empty(60);
    vectors++;
    if (sb.size() != 0) begin errors++; $display("FAIL rerun_drain: %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_ops();
    test_gfmul_random();
    test_load_store();
    test_loop();
    test_branch_wrap();
    test_reset_mid_run();
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
